// File: rtl/noc_ni_param.sv
// Network interface: packetizes a local word stream into head/body/tail flits for a router link,
// and filters/unpacks incoming packets back into a word stream. Holds a generic show-ahead FIFO.

// Generic show-ahead FIFO.
// Latency: a pushed entry is visible at the output on the following cycle.
// Backpressure: push is refused while full, with fullness judged before any same-cycle pop.
module noc_ni_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  output logic                   full,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign pop_vld = (level_q != '0);
  assign push_ok = push_vld && !full;
  assign pop_ok  = pop_vld && pop_rdy;
  // Output is forced to zero while empty so stale entries never reach the link.
  assign pop_dat = pop_vld ? mem_q[rd_q] : '0;
  assign level   = level_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      level_q <= level_d;
    end
  end
endmodule

// NoC network interface, TX packetizer plus RX filter/unpacker.
// Latency: head enters the FIFO one cycle before the first word is taken; RX word valid the cycle after flit accept.
// Backpressure: in_ready drops only when a completed flit cannot enter a full FIFO; rx_ready waits for an empty unpack buffer.
module noc_ni_param #(
  parameter int DATA_W     = 16,
  parameter int WPF        = 4,
  parameter int ADDR_W     = 8,
  parameter int PKT_FLITS  = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int PW        = WPF * DATA_W,
  localparam int FLIT_W    = PW + 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             local_addr,
  input  logic [ADDR_W-1:0]             dest_addr,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [FLIT_W-1:0]             tx_flit,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic [FLIT_W-1:0]             rx_flit,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [ADDR_W-1:0]             rx_src,
  output logic [15:0]                   drop_count,
  output logic                          proto_err
);
  localparam int WCW = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int FCW = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;

  localparam logic [1:0] TYP_INV  = 2'b00;
  localparam logic [1:0] TYP_HEAD = 2'b01;
  localparam logic [1:0] TYP_BODY = 2'b10;
  localparam logic [1:0] TYP_TAIL = 2'b11;

  typedef struct packed {
    logic [1:0]    typ;
    logic [PW-1:0] pl;
  } flit_t;

  typedef enum logic {T_HEAD, T_DATA} tx_state_e;
  typedef enum logic [1:0] {R_HEAD, R_DATA, R_DROP} rx_state_e;

  // ---------------- TX packetizer ----------------
  tx_state_e                   tx_state_q;
  logic [WCW-1:0]              word_cnt_q;
  logic [FCW-1:0]              flit_cnt_q;
  logic [7:0]                  seq_q;
  logic [WPF-1:0][DATA_W-1:0]  wbuf_q;
  logic [WPF-1:0][DATA_W-1:0]  asm_dat;
  logic                        fifo_full;
  logic                        push_vld;
  flit_t                       push_dat;
  logic                        last_word;
  logic                        last_flit;
  logic                        word_acc;

  assign last_word = (word_cnt_q == WCW'(WPF - 1));
  assign last_flit = (flit_cnt_q == FCW'(PKT_FLITS - 1));
  assign in_ready  = (tx_state_q == T_DATA) && !(last_word && fifo_full);
  assign word_acc  = in_valid && in_ready;

  always_comb begin
    asm_dat          = wbuf_q;
    asm_dat[WPF-1]   = in_data;
    push_vld         = 1'b0;
    push_dat         = '0;
    if (tx_state_q == T_HEAD) begin
      push_vld                             = in_valid && !fifo_full;
      push_dat.typ                         = TYP_HEAD;
      push_dat.pl[ADDR_W-1:0]              = dest_addr;
      push_dat.pl[2*ADDR_W-1:ADDR_W]       = local_addr;
      push_dat.pl[2*ADDR_W+7:2*ADDR_W]     = seq_q;
    end else begin
      // The final word bypasses the staging buffer so the flit is written in its accept cycle.
      push_vld     = word_acc && last_word;
      push_dat.typ = last_flit ? TYP_TAIL : TYP_BODY;
      push_dat.pl  = asm_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= T_HEAD;
      word_cnt_q <= '0;
      flit_cnt_q <= '0;
      seq_q      <= '0;
      wbuf_q     <= '0;
    end else begin
      case (tx_state_q)
        T_HEAD: begin
          if (push_vld) tx_state_q <= T_DATA;
        end
        T_DATA: begin
          if (word_acc) begin
            wbuf_q[word_cnt_q] <= in_data;
            if (last_word) begin
              word_cnt_q <= '0;
              if (last_flit) begin
                flit_cnt_q <= '0;
                seq_q      <= seq_q + 8'd1;
                tx_state_q <= T_HEAD;
              end else begin
                flit_cnt_q <= flit_cnt_q + FCW'(1);
              end
            end else begin
              word_cnt_q <= word_cnt_q + WCW'(1);
            end
          end
        end
        default: tx_state_q <= T_HEAD;
      endcase
    end
  end

  noc_ni_fifo #(
    .W     (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .full     (fifo_full),
    .pop_vld  (tx_valid),
    .pop_rdy  (tx_ready),
    .pop_dat  (tx_flit),
    .level    (fifo_level)
  );

  // ---------------- RX filter / unpacker ----------------
  rx_state_e                   rx_state_q;
  logic [WPF-1:0][DATA_W-1:0]  ubuf_q;
  logic [WCW-1:0]              ub_idx_q;
  logic                        ub_vld_q;
  logic                        ub_tail_q;
  logic [ADDR_W-1:0]           rx_src_q;
  logic [15:0]                 drop_cnt_q;
  logic                        proto_err_q;
  flit_t                       rx_f;
  logic                        rx_acc;
  logic                        ub_pop;
  logic                        ub_last;
  logic                        rx_match;

  assign rx_f     = rx_flit;
  // rx_ready is held low through reset so every output reads zero while reset is applied.
  assign rx_ready = !reset && ((rx_state_q != R_DATA) || !ub_vld_q);
  assign rx_acc   = rx_valid && rx_ready;
  assign ub_last  = (ub_idx_q == WCW'(WPF - 1));
  assign ub_pop   = ub_vld_q && out_ready;
  assign rx_match = (rx_f.pl[ADDR_W-1:0] == local_addr);

  assign out_valid  = ub_vld_q;
  assign out_data   = ub_vld_q ? ubuf_q[ub_idx_q] : '0;
  assign out_last   = ub_vld_q && ub_tail_q && ub_last;
  assign rx_src     = rx_src_q;
  assign drop_count = drop_cnt_q;
  assign proto_err  = proto_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q  <= R_HEAD;
      ubuf_q      <= '0;
      ub_idx_q    <= '0;
      ub_vld_q    <= 1'b0;
      ub_tail_q   <= 1'b0;
      rx_src_q    <= '0;
      drop_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= 1'b0;
      if (ub_pop) begin
        if (ub_last) begin
          ub_vld_q <= 1'b0;
          ub_idx_q <= '0;
          if (ub_tail_q) rx_state_q <= R_HEAD;
        end else begin
          ub_idx_q <= ub_idx_q + WCW'(1);
        end
      end
      // A flit can only be accepted in R_DATA once the buffer is empty, so no pop overlaps a load.
      if (rx_acc) begin
        case (rx_state_q)
          R_HEAD, R_DATA: begin
            if (rx_f.typ == TYP_HEAD) begin
              if (rx_state_q == R_DATA) proto_err_q <= 1'b1;
              if (rx_match) begin
                rx_src_q   <= rx_f.pl[2*ADDR_W-1:ADDR_W];
                rx_state_q <= R_DATA;
              end else begin
                rx_state_q <= R_DROP;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
              end
            end else if ((rx_state_q == R_DATA) && (rx_f.typ != TYP_INV)) begin
              ubuf_q    <= rx_f.pl;
              ub_vld_q  <= 1'b1;
              ub_idx_q  <= '0;
              ub_tail_q <= (rx_f.typ == TYP_TAIL);
            end else begin
              proto_err_q <= 1'b1;
            end
          end
          R_DROP: begin
            if (rx_f.typ == TYP_TAIL) rx_state_q <= R_HEAD;
          end
          default: rx_state_q <= R_HEAD;
        endcase
      end
    end
  end
endmodule
